int_arbiter: RTL and testbench

Interrupt arbiter and trap-request sequencer for the machine/supervisor CSR unit. It combines raw interrupt sources with the mie/sie enable image, the mideleg mask, the current privilege and the mstatus global enables, then selects the highest-priority eligible interrupt. It raises a held request to the pipeline commit stage and sequences trap entry through a request/acknowledge handshake. It sits between the CSR block and the exception/commit unit.

---
 rtl/int_arbiter_if.sv | 28 ++
 rtl/int_arbiter.sv | 75 +++++++
 tb/tb_int_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/int_arbiter_if.sv
// int_arbiter_if: interrupt sources, CSR image, and trap handshake between the CSR unit and int_arbiter
interface int_arbiter_if;
  logic        m_ext_int;
  logic        s_ext_int;
  logic        m_tim_int;
  logic        m_soft_int;
  logic [63:0] mip_sw;
  logic [63:0] m_s_ie;
  logic [63:0] mideleg;
  logic [1:0]  priv;
  logic        mstatus_mie;
  logic        mstatus_sie;
  logic        int_ack;
  logic        int_req;
  logic [63:0] int_cause;
  logic        int_to_s;
  logic        wfi_wake;
  modport slave (
    input  m_ext_int, s_ext_int, m_tim_int, m_soft_int, mip_sw, m_s_ie, mideleg,
           priv, mstatus_mie, mstatus_sie, int_ack,
    output int_req, int_cause, int_to_s, wfi_wake
  );
  modport master (
    output m_ext_int, s_ext_int, m_tim_int, m_soft_int, mip_sw, m_s_ie, mideleg,
           priv, mstatus_mie, mstatus_sie, int_ack,
    input  int_req, int_cause, int_to_s, wfi_wake
  );
endinterface

// File: rtl/int_arbiter.sv
// int_arbiter: picks the highest-priority eligible M/S interrupt and sequences trap entry by req/ack.
// Define INT_SYNC_EN to pass the four hardware interrupt lines through 2-flop synchronizers.
module int_arbiter (
  input logic          clk,
  input logic          rst,
  int_arbiter_if.slave irq
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] ENTRY = 2'd2;
  logic [3:0]  src;
  logic [15:0] pend, act, deleg, elig;
  logic        priv_m, priv_s, priv_u, m_ok, s_ok, req;
  logic [3:0]  win, code_q, code_d;
  logic [1:0]  state_q, state_d;
  logic        to_s_q, to_s_d;
  logic        unused_bits;
`ifdef INT_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {irq.m_ext_int, irq.s_ext_int, irq.m_tim_int, irq.m_soft_int};
      sync2_q <= sync1_q;
    end
  end
  assign src = sync2_q;
`else
  assign src = {irq.m_ext_int, irq.s_ext_int, irq.m_tim_int, irq.m_soft_int};
`endif
  assign pend = {4'b0, src[3], 1'b0, src[2] | irq.mip_sw[9], 1'b0, src[1], 1'b0,
                 irq.mip_sw[5], 1'b0, src[0], 1'b0, irq.mip_sw[1], 1'b0};
  assign act   = pend & irq.m_s_ie[15:0];
  assign deleg = irq.mideleg[15:0] & 16'h0222;
  assign priv_m = irq.priv[1];
  assign priv_s = irq.priv == 2'b01;
  assign priv_u = irq.priv == 2'b00;
  assign m_ok   = !priv_m || irq.mstatus_mie;
  assign s_ok   = priv_u || (priv_s && irq.mstatus_sie);
  assign elig   = act & ((deleg & {16{s_ok}}) | (~deleg & {16{m_ok}}));
  assign win = elig[11] ? 4'd11 : elig[3] ? 4'd3 : elig[7] ? 4'd7 :
               elig[9]  ? 4'd9  : elig[1] ? 4'd1 : 4'd5;
  // Cause and target are frozen while requesting; only ack or loss of the latched bit leaves REQ.
  always_comb begin
    state_d = IDLE;
    code_d  = code_q;
    to_s_d  = to_s_q;
    if (state_q == IDLE && |elig) begin
      state_d = REQ;
      code_d  = win;
      to_s_d  = deleg[win];
    end else if (state_q == REQ)
      state_d = irq.int_ack ? ENTRY : elig[code_q] ? REQ : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      to_s_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      to_s_q  <= to_s_d;
    end
  end
  assign req           = state_q == REQ;
  assign irq.int_req   = req;
  assign irq.int_cause = req ? {1'b1, 59'b0, code_q} : 64'b0;
  assign irq.int_to_s  = req && to_s_q;
  assign irq.wfi_wake  = |act;
  assign unused_bits = ^{irq.mip_sw[63:10], irq.mip_sw[8:6], irq.mip_sw[4:2], irq.mip_sw[0],
                         irq.m_s_ie[63:16], irq.mideleg[63:16]};
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed checks of priority, eligibility, handshake, withdrawal and reset.
module tb_int_arbiter;
`ifdef INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [63:0] C11 = 64'h8000_0000_0000_000B;
  localparam logic [63:0] C3  = 64'h8000_0000_0000_0003;
  localparam logic [63:0] C7  = 64'h8000_0000_0000_0007;
  localparam logic [63:0] C9  = 64'h8000_0000_0000_0009;
  localparam logic [63:0] C1  = 64'h8000_0000_0000_0001;
  localparam logic [63:0] C5  = 64'h8000_0000_0000_0005;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int_arbiter_if bif ();
  int_arbiter dut (.clk(clk), .rst(rst), .irq(bif.slave));
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ack_once();
    bif.int_ack = 1'b1;
    cyc(1);
    bif.int_ack = 1'b0;
  endtask
  initial begin
    bif.m_ext_int = 0; bif.s_ext_int = 0; bif.m_tim_int = 0; bif.m_soft_int = 0;
    bif.mip_sw = '0; bif.m_s_ie = '0; bif.mideleg = '0; bif.priv = 2'b00;
    bif.mstatus_mie = 0; bif.mstatus_sie = 0; bif.int_ack = 0;
    cyc(2);
    chk("rst_req", 64'(bif.int_req), 64'd0);
    chk("rst_cause", bif.int_cause, 64'd0);
    chk("rst_to_s", 64'(bif.int_to_s), 64'd0);
    chk("rst_wfi", 64'(bif.wfi_wake), 64'd0);
    rst = 0;
    // external M interrupt from U mode
    bif.m_s_ie = 64'h800;
    bif.m_ext_int = 1;
    cyc(LAT);
    chk("mext_req", 64'(bif.int_req), 64'd1);
    chk("mext_cause", bif.int_cause, C11);
    chk("mext_to_s", 64'(bif.int_to_s), 64'd0);
    ack_once();
    chk("entry_req", 64'(bif.int_req), 64'd0);
    cyc(1);
    chk("idle_req", 64'(bif.int_req), 64'd0);
    cyc(1);
    chk("rereq", 64'(bif.int_req), 64'd1);
    bif.m_ext_int = 0;
    cyc(LAT);
    chk("mext_drop", 64'(bif.int_req), 64'd0);
    // all six pending: priority walk
    bif.m_s_ie = 64'hAAA;
    bif.mip_sw = 64'h22;
    bif.s_ext_int = 1; bif.m_soft_int = 1; bif.m_tim_int = 1; bif.m_ext_int = 1;
    cyc(LAT);
    chk("prio_11", bif.int_cause, C11);
    bif.m_ext_int = 0;
    ack_once();
    cyc(2);
    chk("prio_3", bif.int_cause, C3);
    bif.m_soft_int = 0;
    ack_once();
    cyc(2);
    chk("prio_7", bif.int_cause, C7);
    bif.m_tim_int = 0;
    ack_once();
    cyc(2);
    chk("prio_9", bif.int_cause, C9);
    bif.s_ext_int = 0;
    ack_once();
    cyc(2);
    chk("prio_1", bif.int_cause, C1);
    bif.mip_sw = 64'h20;
    ack_once();
    cyc(2);
    chk("prio_5", bif.int_cause, C5);
    bif.mip_sw = 64'h0;
    ack_once();
    cyc(2);
    chk("prio_none", 64'(bif.int_req), 64'd0);
    // M mode gated by mstatus_mie
    bif.priv = 2'b11;
    bif.m_s_ie = 64'h80;
    bif.m_tim_int = 1;
    cyc(LAT + 1);
    chk("mie0_req", 64'(bif.int_req), 64'd0);
    chk("mie0_wfi", 64'(bif.wfi_wake), 64'd1);
    bif.mstatus_mie = 1;
    cyc(1);
    chk("mie1_cause", bif.int_cause, C7);
    // withdrawal, then ack winning over simultaneous loss of eligibility
    bif.mstatus_mie = 0;
    cyc(1);
    chk("withdraw", 64'(bif.int_req), 64'd0);
    bif.mstatus_mie = 1;
    cyc(1);
    chk("rereq_tim", 64'(bif.int_req), 64'd1);
    bif.mstatus_mie = 0;
    ack_once();
    bif.mstatus_mie = 1;
    chk("ack_win_entry", 64'(bif.int_req), 64'd0);
    cyc(1);
    chk("ack_win_idle", 64'(bif.int_req), 64'd0);
    cyc(1);
    chk("ack_win_req", 64'(bif.int_req), 64'd1);
    // reset while in REQ, with a pending ack discarded
    rst = 1;
    bif.int_ack = 1;
    cyc(1);
    chk("rreq_req", 64'(bif.int_req), 64'd0);
    chk("rreq_cause", bif.int_cause, 64'd0);
    rst = 0;
    bif.int_ack = 0;
    cyc(LAT);
    chk("post_rst", bif.int_cause, C7);
    // delegated S external interrupt
    bif.m_tim_int = 0;
    bif.m_s_ie = 64'h200;
    bif.mideleg = 64'h200;
    bif.s_ext_int = 1;
    cyc(LAT + 1);
    chk("deleg_m_req", 64'(bif.int_req), 64'd0);
    chk("deleg_m_wfi", 64'(bif.wfi_wake), 64'd1);
    bif.priv = 2'b01;
    cyc(2);
    chk("deleg_s_sie0", 64'(bif.int_req), 64'd0);
    bif.mstatus_sie = 1;
    cyc(1);
    chk("deleg_s_cause", bif.int_cause, C9);
    chk("deleg_s_to_s", 64'(bif.int_to_s), 64'd1);
    bif.s_ext_int = 0;
    ack_once();
    bif.s_ext_int = 1;
    bif.priv = 2'b00;
    bif.mstatus_sie = 0;
    cyc(LAT + 1);
    chk("deleg_u_cause", bif.int_cause, C9);
    chk("deleg_u_to_s", 64'(bif.int_to_s), 64'd1);
    // priv 10 acts as M; mideleg bit 7 is not honoured
    bif.s_ext_int = 0;
    ack_once();
    bif.m_s_ie = 64'h80;
    bif.mideleg = '1;
    bif.m_tim_int = 1;
    bif.priv = 2'b10;
    bif.mstatus_mie = 1;
    cyc(LAT + 1);
    chk("nodeleg7_cause", bif.int_cause, C7);
    chk("nodeleg7_to_s", 64'(bif.int_to_s), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
